npu_spi_cfg_slave: RTL and testbench

SPI slave and configuration-frame decoder for the NPU host port. It oversamples the host SPI bus in the `npu_clk` domain and assembles LSB-first 16-bit words. It decodes header/address/data frames into single-cycle register-bus write and read strobes. On reads, it returns register data on MISO during the data word.

---
 rtl/npu_spi_pkg.sv | 15 +
 rtl/npu_spi_sync_edge.sv | 47 ++++
 rtl/npu_spi_cfg_slave.sv | 233 +++++++++++++++++++++++
 tb/tb_npu_spi_cfg_slave.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_spi_pkg.sv
// Shared types and constants for the NPU host-port SPI configuration slave.
// Provides the frame-decoder state enum and the header/command word values.
package npu_spi_pkg;

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } spi_state_t;

   localparam logic [15:0] SPI_HDR_WORD = 16'hFFFF;
   localparam logic [7:0]  SPI_CMD_WR   = 8'hFF;
   localparam logic [7:0]  SPI_CMD_RD   = 8'h00;

endpackage

// File: rtl/npu_spi_sync_edge.sv
// Synchronizer chain plus registered rise/fall pulse detection for one
// asynchronous input.
// Ports: clk, rst (async active-high), din (async input),
//        sync (synchronized level), rise / fall (one-cycle pulses).
module npu_spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain_q, chain_d;
   logic                   prev_q,  prev_d;
   logic                   rise_q,  rise_d;
   logic                   fall_q,  fall_d;

   always_comb begin
      chain_d = {chain_q[SYNC_STAGES-2:0], din};
      prev_d  = chain_q[SYNC_STAGES-1];
      rise_d  = chain_q[SYNC_STAGES-1] & ~prev_q;
      fall_d  = ~chain_q[SYNC_STAGES-1] & prev_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain_q <= {SYNC_STAGES{RST_VAL}};
         prev_q  <= RST_VAL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         chain_q <= chain_d;
         prev_q  <= prev_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign sync = chain_q[SYNC_STAGES-1];
   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: rtl/npu_spi_cfg_slave.sv
// SPI mode-0 slave and configuration-frame decoder for the NPU host port.
// Oversamples SPI in npu_clk, assembles LSB-first 16-bit words and decodes
// header / address / data frames into register-bus strobes; read data is
// shifted back on spi_miso during the data word.
// Ports: npu_clk, npu_reset (async active-high), spi_sclk/spi_ss/spi_mosi in,
//        spi_miso out, reg_wr_en/reg_rd_en/reg_addr/reg_wdata out,
//        reg_rdata in, frame_err pulse, busy.
// Optional: define NPU_SPI_TIMEOUT_EN to resync a frame stalled with
//           spi_ss high for TIMEOUT_CYC cycles.
module npu_spi_cfg_slave
   import npu_spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic        npu_clk,
   input  logic        npu_reset,
   input  logic        spi_sclk,
   input  logic        spi_ss,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        reg_wr_en,
   output logic        reg_rd_en,
   output logic [7:0]  reg_addr,
   output logic [15:0] reg_wdata,
   input  logic [15:0] reg_rdata,
   output logic        frame_err,
   output logic        busy
);

   logic sclk_sync, sclk_rise, sclk_fall;
   logic ss_sync, ss_rise, ss_fall;
   logic edges_unused;

   npu_spi_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (1'b0)
   ) u_sclk_sync (
      .clk  (npu_clk),
      .rst  (npu_reset),
      .din  (spi_sclk),
      .sync (sclk_sync),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   // Slave select idles high, so its chain resets high to avoid a
   // phantom select edge after reset.
   npu_spi_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (1'b1)
   ) u_ss_sync (
      .clk  (npu_clk),
      .rst  (npu_reset),
      .din  (spi_ss),
      .sync (ss_sync),
      .rise (ss_rise),
      .fall (ss_fall)
   );

   assign edges_unused = sclk_sync ^ ss_rise ^ ss_fall;

   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

   spi_state_t  state_q,     state_d;
   logic [3:0]  bit_cnt_q,   bit_cnt_d;
   logic [15:0] word_q,      word_d;
   logic        is_wr_q,     is_wr_d;
   logic [7:0]  reg_addr_q,  reg_addr_d;
   logic [15:0] reg_wdata_q, reg_wdata_d;
   logic        reg_wr_en_q, reg_wr_en_d;
   logic        reg_rd_en_q, reg_rd_en_d;
   logic        rd_load_q,   rd_load_d;
   logic        frame_err_q, frame_err_d;
   logic [15:0] tx_q,        tx_d;

   logic        rx_bit;
   logic        word_done;
   logic [15:0] full_word;
   logic        busy_w;
   logic        to_fire;

   assign rx_bit = mosi_sync_q[SYNC_STAGES-1];
   assign busy_w = (state_q != HUNT) || (bit_cnt_q != 4'd0);

`ifdef NPU_SPI_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            to_run;

   // Only a stalled frame (select released mid-frame) is timed.
   assign to_run  = ss_sync && busy_w;
   assign to_fire = to_run && (to_cnt_q == TO_LAST);

   always_comb begin
      to_cnt_d = '0;
      if (to_run && !to_fire) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge npu_clk or posedge npu_reset) begin
      if (npu_reset) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`else
   localparam int timeout_cyc_unused = TIMEOUT_CYC;
   assign to_fire = 1'b0;
`endif

   always_comb begin
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      word_d      = word_q;
      is_wr_d     = is_wr_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_wr_en_d = 1'b0;
      reg_rd_en_d = 1'b0;
      rd_load_d   = reg_rd_en_q;
      frame_err_d = 1'b0;
      tx_d        = tx_q;
      word_done   = 1'b0;
      full_word   = word_q;

      if (sclk_rise && !ss_sync) begin
         full_word[bit_cnt_q] = rx_bit;
         word_d    = full_word;
         bit_cnt_d = bit_cnt_q + 4'd1;
         word_done = (bit_cnt_q == 4'hF);
      end

      // Read data is captured one cycle after the read strobe. Falls
      // only shift once the data word has started (bit_cnt != 0), so
      // the trailing fall of the address word keeps bit 0 on the pin.
      if (rd_load_q) begin
         tx_d = reg_rdata;
      end else if (sclk_fall && !ss_sync && state_q == DATA &&
                   !is_wr_q && bit_cnt_q != 4'd0) begin
         tx_d = {1'b0, tx_q[15:1]};
      end

      if (word_done) begin
         unique case (state_q)
            HUNT: begin
               if (full_word == SPI_HDR_WORD) begin
                  state_d = ADDR;
               end else begin
                  frame_err_d = 1'b1;
                  bit_cnt_d   = 4'd0;
               end
            end
            ADDR: begin
               if (full_word[15:8] == SPI_CMD_WR) begin
                  reg_addr_d = full_word[7:0];
                  is_wr_d    = 1'b1;
                  state_d    = DATA;
               end else if (full_word[15:8] == SPI_CMD_RD) begin
                  reg_addr_d  = full_word[7:0];
                  is_wr_d     = 1'b0;
                  reg_rd_en_d = 1'b1;
                  state_d     = DATA;
               end else begin
                  frame_err_d = 1'b1;
                  tx_d        = '0;
                  state_d     = HUNT;
               end
            end
            DATA: begin
               if (is_wr_q) begin
                  reg_wr_en_d = 1'b1;
                  reg_wdata_d = full_word;
               end
               tx_d    = '0;
               state_d = HUNT;
            end
            default: begin
               state_d = HUNT;
            end
         endcase
      end else if (to_fire) begin
         state_d     = HUNT;
         bit_cnt_d   = 4'd0;
         tx_d        = '0;
         frame_err_d = 1'b1;
      end
   end

   always_ff @(posedge npu_clk or posedge npu_reset) begin
      if (npu_reset) begin
         mosi_sync_q <= '0;
         state_q     <= HUNT;
         bit_cnt_q   <= 4'd0;
         word_q      <= '0;
         is_wr_q     <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_wr_en_q <= 1'b0;
         reg_rd_en_q <= 1'b0;
         rd_load_q   <= 1'b0;
         frame_err_q <= 1'b0;
         tx_q        <= '0;
      end else begin
         mosi_sync_q <= mosi_sync_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         word_q      <= word_d;
         is_wr_q     <= is_wr_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_wr_en_q <= reg_wr_en_d;
         reg_rd_en_q <= reg_rd_en_d;
         rd_load_q   <= rd_load_d;
         frame_err_q <= frame_err_d;
         tx_q        <= tx_d;
      end
   end

   assign spi_miso  = tx_q[0];
   assign reg_wr_en = reg_wr_en_q;
   assign reg_rd_en = reg_rd_en_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_w;

endmodule

// File: tb/tb_npu_spi_cfg_slave.sv
// Self-checking bench for npu_spi_cfg_slave: word-level frame model,
// register-file model, MISO listener and strobe scoreboard.
module tb_npu_spi_cfg_slave;

   localparam int SYNC = 2;
   localparam int TO   = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        sclk, ss, mosi;
   logic        miso, wr_en, rd_en, ferr, busy;
   logic [7:0]  addr;
   logic [15:0] wdata, rdata;

   npu_spi_cfg_slave #(
      .SYNC_STAGES (SYNC),
      .TIMEOUT_CYC (TO)
   ) dut (
      .npu_clk   (clk),
      .npu_reset (rst),
      .spi_sclk  (sclk),
      .spi_ss    (ss),
      .spi_mosi  (mosi),
      .spi_miso  (miso),
      .reg_wr_en (wr_en),
      .reg_rd_en (rd_en),
      .reg_addr  (addr),
      .reg_wdata (wdata),
      .reg_rdata (rdata),
      .frame_err (ferr),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Register file seen by the DUT (combinational read).
   logic [15:0] regs [256];
   logic [15:0] exp_regs [256];
   assign rdata = regs[addr];
   always @(posedge clk) if (wr_en) regs[addr] <= wdata;

   typedef struct {
      int          kind;   // 0 write, 1 read, 2 error
      logic [7:0]  addr;
      logic [15:0] data;
   } ev_t;

   ev_t         expq [$];
   int          m_state;   // 0 hunt, 1 expect address, 2 expect data
   bit          m_wr;
   logic [7:0]  m_addr;

   int n_cmp = 0;
   int n_bad = 0;
   int n_wr = 0, n_rd = 0, n_err = 0;
   int last_err_cyc = 0;
   int last_ss_hi_cyc = 0;
   logic [15:0] last_mi;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic void push_ev(input int k, input logic [7:0] a,
                                   input logic [15:0] d);
      ev_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      expq.push_back(e);
   endfunction

   // Word-level protocol rules.
   function automatic void model_word(input logic [15:0] w);
      case (m_state)
         0: begin
            if (w == 16'hFFFF) m_state = 1;
            else push_ev(2, 8'h0, 16'h0);
         end
         1: begin
            if (w[15:8] == 8'hFF) begin
               m_addr = w[7:0]; m_wr = 1'b1; m_state = 2;
            end else if (w[15:8] == 8'h00) begin
               m_addr = w[7:0]; m_wr = 1'b0; m_state = 2;
               push_ev(1, w[7:0], 16'h0);
            end else begin
               push_ev(2, 8'h0, 16'h0);
               m_state = 0;
            end
         end
         default: begin
            if (m_wr) begin
               push_ev(0, m_addr, w);
               exp_regs[m_addr] = w;
            end
            m_state = 0;
         end
      endcase
   endfunction

   // Strobe scoreboard and idle-MISO check, every cycle.
   ev_t mon_e;
   int  mon_kind;
   always @(negedge clk) begin
      if (!rst) begin
         if (!busy) check("miso_idle", 32'(miso), 32'd0);
         if (wr_en || rd_en || ferr) begin
            check("one_strobe", 32'($countones({wr_en, rd_en, ferr})), 32'd1);
            if (wr_en) n_wr++;
            if (rd_en) n_rd++;
            if (ferr) begin
               n_err++;
               last_err_cyc = cyc;
            end
            if (expq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_strobe: got wr=%0b rd=%0b err=%0b required none",
                        wr_en, rd_en, ferr);
            end else begin
               mon_e = expq.pop_front();
               mon_kind = wr_en ? 0 : (rd_en ? 1 : 2);
               check("ev_kind", mon_kind, mon_e.kind);
               if (mon_e.kind != 2) check("ev_addr", 32'(addr), 32'(mon_e.addr));
               if (mon_e.kind == 0) check("ev_wdata", 32'(wdata), 32'(mon_e.data));
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, output logic [7:0] mi);
      mi = 8'h0;
      ss = 1'b0;
      repeat ($urandom_range(2, 4)) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         mosi = b[i];
         repeat ($urandom_range(3, 5)) @(negedge clk);
         mi[i] = miso;
         sclk = 1'b1;
         repeat ($urandom_range(3, 4)) @(negedge clk);
         sclk = 1'b0;
         repeat ($urandom_range(5, 7)) @(negedge clk);
      end
      ss = 1'b1;
      last_ss_hi_cyc = cyc;
      repeat ($urandom_range(3, 8)) @(negedge clk);
   endtask

   task automatic do_word(input logic [15:0] w);
      logic [15:0] exp_mi;
      logic [7:0]  lo, hi;
      exp_mi = (m_state == 2 && !m_wr) ? exp_regs[m_addr] : 16'h0;
      model_word(w);
      send_byte(w[7:0], lo);
      send_byte(w[15:8], hi);
      last_mi = {hi, lo};
      check("miso_word", 32'(last_mi), 32'(exp_mi));
   endtask

   task automatic settle(input string tag);
      repeat (12) @(negedge clk);
      check({tag, "_pending"}, expq.size(), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'(m_state != 0));
      check({tag, "_addr"}, 32'(addr), 32'(m_addr));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_miso"},  32'(miso),  32'd0);
      check({tag, "_wr"},    32'(wr_en), 32'd0);
      check({tag, "_rd"},    32'(rd_en), 32'd0);
      check({tag, "_addr"},  32'(addr),  32'd0);
      check({tag, "_wdata"}, 32'(wdata), 32'd0);
      check({tag, "_err"},   32'(ferr),  32'd0);
      check({tag, "_busy"},  32'(busy),  32'd0);
   endtask

   task automatic run_random(input int frames);
      int          k;
      logic [7:0]  a;
      logic [15:0] d;
      for (int f = 0; f < frames; f++) begin
         k = $urandom_range(0, 9);
         a = 8'($urandom_range(0, 7));
         d = 16'($urandom);
         if (k <= 3) begin
            do_word(16'hFFFF); do_word({8'hFF, a}); do_word(d);
         end else if (k <= 7) begin
            do_word(16'hFFFF); do_word({8'h00, a}); do_word(d);
         end else if (k == 8) begin
            do_word(d);
         end else begin
            do_word(16'hFFFF); do_word(d);
         end
         settle("rand");
      end
   endtask

   int wr0, rd0, err0;
   logic [7:0] junk;

   initial begin
      rst = 1'b1; sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
      for (int i = 0; i < 256; i++) begin
         regs[i] = 16'($urandom);
         exp_regs[i] = regs[i];
      end
      m_state = 0; m_wr = 1'b0; m_addr = 8'h0;
      repeat (5) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Write frame.
      wr0 = n_wr; err0 = n_err;
      do_word(16'hFFFF); do_word(16'hFF01); do_word(16'h00FF);
      settle("wr");
      check("wr_count", n_wr - wr0, 32'd1);
      check("wr_err_count", n_err - err0, 32'd0);
      check("wr_addr_lit", 32'(addr), 32'h01);
      check("wr_wdata_lit", 32'(wdata), 32'h00FF);

      // Read frame.
      regs[1] = 16'hA5C3; exp_regs[1] = 16'hA5C3;
      rd0 = n_rd;
      do_word(16'hFFFF); do_word(16'h0001); do_word(16'h0000);
      check("rd_miso_lit", 32'(last_mi), 32'hA5C3);
      settle("rd");
      check("rd_count", n_rd - rd0, 32'd1);

      // Bad header, then a good write.
      wr0 = n_wr; rd0 = n_rd; err0 = n_err;
      do_word(16'h1234);
      settle("badhdr");
      check("badhdr_err", n_err - err0, 32'd1);
      check("badhdr_strobes", (n_wr - wr0) + (n_rd - rd0), 32'd0);
      do_word(16'hFFFF); do_word(16'hFF22); do_word(16'hBEEF);
      settle("afterhdr");
      check("afterhdr_wdata_lit", 32'(wdata), 32'hBEEF);
      check("afterhdr_addr_lit", 32'(addr), 32'h22);

      // Bad command.
      wr0 = n_wr; rd0 = n_rd; err0 = n_err;
      do_word(16'hFFFF); do_word(16'h5501);
      settle("badcmd");
      check("badcmd_err", n_err - err0, 32'd1);
      check("badcmd_strobes", (n_wr - wr0) + (n_rd - rd0), 32'd0);
      check("badcmd_idle", 32'(busy), 32'd0);

      // Reset in the middle of the address word.
      do_word(16'hFFFF);
      send_byte(8'h05, junk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_vals("midrst");
      m_state = 0; m_wr = 1'b0; m_addr = 8'h0;
      expq.delete();
      rst = 1'b0;
      repeat (5) @(negedge clk);
      do_word(16'hFFFF); do_word(16'hFF07); do_word(16'h1357);
      settle("postrst");
      check("postrst_wdata_lit", 32'(wdata), 32'h1357);

`ifdef NPU_SPI_TIMEOUT_EN
      err0 = n_err;
      do_word(16'hFFFF);
      push_ev(2, 8'h0, 16'h0);
      repeat (100) @(negedge clk);
      m_state = 0;
      check("to_err", n_err - err0, 32'd1);
      check("to_latency_ok",
            32'((last_err_cyc - last_ss_hi_cyc) >= TO &&
                (last_err_cyc - last_ss_hi_cyc) <= TO + 8), 32'd1);
      check("to_idle", 32'(busy), 32'd0);
      do_word(16'hFFFF); do_word(16'hFF09); do_word(16'h2468);
      settle("postto");
      check("postto_wdata_lit", 32'(wdata), 32'h2468);
`endif

      run_random(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
